// File: rtl/uart_fifo_core_pkg.sv
// Shared encodings and oversampling constants for the
// uart_fifo_core UART and its FIFOs.
package uart_fifo_core_pkg;

  typedef enum logic [1:0] {
    PM_NONE  = 2'b00,
    PM_EVEN  = 2'b01,
    PM_ODD   = 2'b10,
    PM_NONE2 = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned OS_TICKS = 16;
  localparam int unsigned MID_TICK = 7;

  function automatic logic par_en(input logic [1:0] pm);
    return (pm == PM_EVEN) || (pm == PM_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, registered flags, first-word
// fall-through read port (reads 0 while empty).
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [2**FIFO_AW];
  logic [FIFO_AW:0] wp_q, wp_d;
  logic [FIFO_AW:0] rp_q, rp_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic do_wr, do_rd;

  always_comb begin
    do_rd = rd && !empty_q;
    do_wr = wr && (!full_q || do_rd);
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (do_wr) wp_d = wp_q + 1'b1;
    if (do_rd) rp_d = rp_q + 1'b1;
    empty_d = (wp_d == rp_d);
    full_d  = (wp_d[FIFO_AW] != rp_d[FIFO_AW]) &&
              (wp_d[FIFO_AW-1:0] == rp_d[FIFO_AW-1:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q[FIFO_AW-1:0]] <= wdata;
  end

  assign rdata = empty_q ? '0 : mem_q[rp_q[FIFO_AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex 16x-oversampled UART with TX/RX FIFOs,
// runtime divisor and parity, sticky error flags.
module uart_fifo_core
  import uart_fifo_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_W     = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_W-1:0]     dvsr,
  input  logic [1:0]            parity_mode,
  input  logic                  rx,
  output logic                  tx,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_rd,
  output logic                  rx_empty,
  output logic                  rx_full,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  input  logic                  err_clr
);

  localparam int S_W = 6;
  localparam int N_W = 4;

  logic [DVSR_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic tick;
  logic [1:0] sync_q;
  logic rx_s;

  // Divisor is latched into lim_q only at wrap.
  always_comb begin
    tick  = (cnt_q == lim_q);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    lim_d = tick ? dvsr : lim_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      lim_q  <= '0;
      sync_q <= 2'b11;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  uart_state_e rx_st_q;
  logic [S_W-1:0] rx_s_q;
  logic [N_W-1:0] rx_n_q;
  logic [DATA_WIDTH-1:0] rx_b_q;
  logic [1:0] rx_pm_q;
  logic rx_par_q, rx_done_q, rx_stop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st_q   <= ST_IDLE;
      rx_s_q    <= '0;
      rx_n_q    <= '0;
      rx_b_q    <= '0;
      rx_pm_q   <= '0;
      rx_par_q  <= 1'b0;
      rx_done_q <= 1'b0;
      rx_stop_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      unique case (rx_st_q)
        ST_IDLE: if (!rx_s) begin
          rx_st_q <= ST_START;
          rx_s_q  <= '0;
          rx_pm_q <= parity_mode;
        end
        ST_START: if (tick) begin
          if (rx_s_q == S_W'(MID_TICK)) begin
            rx_s_q  <= '0;
            rx_n_q  <= '0;
            rx_st_q <= rx_s ? ST_IDLE : ST_DATA;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        ST_DATA: if (tick) begin
          if (rx_s_q == S_W'(OS_TICKS - 1)) begin
            rx_s_q <= '0;
            rx_b_q <= {rx_s, rx_b_q[DATA_WIDTH-1:1]};
            if (rx_n_q == N_W'(DATA_WIDTH - 1))
              rx_st_q <= par_en(rx_pm_q) ? ST_PARITY : ST_STOP;
            else rx_n_q <= rx_n_q + 1'b1;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        ST_PARITY: if (tick) begin
          if (rx_s_q == S_W'(OS_TICKS - 1)) begin
            rx_s_q   <= '0;
            rx_par_q <= rx_s;
            rx_st_q  <= ST_STOP;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        ST_STOP: if (tick) begin
          if (rx_s_q == S_W'(SB_TICK - 1)) begin
            rx_done_q <= 1'b1;
            rx_stop_q <= rx_s;
            rx_st_q   <= ST_IDLE;
          end else rx_s_q <= rx_s_q + 1'b1;
        end
        default: rx_st_q <= ST_IDLE;
      endcase
    end
  end

  logic rx_push, rx_pmis, ovr_set;
  logic perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;

  // Error sets are applied after the clear so a coincident event wins.
  always_comb begin
    rx_push = rx_done_q && rx_stop_q;
    rx_pmis = par_en(rx_pm_q) &&
              (rx_par_q != ((^rx_b_q) ^ (rx_pm_q == PM_ODD)));
    ovr_set = rx_push && rx_full && !rx_rd;
    perr_d  = err_clr ? 1'b0 : perr_q;
    ferr_d  = err_clr ? 1'b0 : ferr_q;
    oerr_d  = err_clr ? 1'b0 : oerr_q;
    if (rx_push && rx_pmis) perr_d = 1'b1;
    if (rx_done_q && !rx_stop_q) ferr_d = 1'b1;
    if (ovr_set) oerr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      oerr_q <= oerr_d;
    end
  end

  uart_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_push),
    .wdata (rx_b_q),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  uart_state_e tx_st_q;
  logic [S_W-1:0] tx_s_q;
  logic [N_W-1:0] tx_n_q;
  logic [DATA_WIDTH-1:0] tx_b_q, tx_head;
  logic [1:0] tx_pm_q;
  logic tx_par_q, tx_q, tx_busy_q;
  logic tx_last, tx_pop;

  // Frames start on a tick so every bit is exactly 16 ticks long.
  always_comb begin
    tx_last = (tx_st_q == ST_STOP) && tick &&
              (tx_s_q == S_W'(SB_TICK - 1));
    tx_pop  = !tx_empty && tick &&
              ((tx_st_q == ST_IDLE) || tx_last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st_q   <= ST_IDLE;
      tx_s_q    <= '0;
      tx_n_q    <= '0;
      tx_b_q    <= '0;
      tx_pm_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else if (tx_pop) begin
      tx_st_q   <= ST_START;
      tx_s_q    <= '0;
      tx_b_q    <= tx_head;
      tx_pm_q   <= parity_mode;
      tx_par_q  <= (^tx_head) ^ (parity_mode == PM_ODD);
      tx_q      <= 1'b0;
      tx_busy_q <= 1'b1;
    end else begin
      unique case (tx_st_q)
        ST_IDLE: tx_q <= 1'b1;
        ST_START: if (tick) begin
          if (tx_s_q == S_W'(OS_TICKS - 1)) begin
            tx_s_q  <= '0;
            tx_n_q  <= '0;
            tx_q    <= tx_b_q[0];
            tx_st_q <= ST_DATA;
          end else tx_s_q <= tx_s_q + 1'b1;
        end
        ST_DATA: if (tick) begin
          if (tx_s_q == S_W'(OS_TICKS - 1)) begin
            tx_s_q <= '0;
            if (tx_n_q == N_W'(DATA_WIDTH - 1)) begin
              tx_st_q <= par_en(tx_pm_q) ? ST_PARITY : ST_STOP;
              tx_q    <= par_en(tx_pm_q) ? tx_par_q : 1'b1;
            end else begin
              tx_n_q <= tx_n_q + 1'b1;
              tx_b_q <= tx_b_q >> 1;
              tx_q   <= tx_b_q[1];
            end
          end else tx_s_q <= tx_s_q + 1'b1;
        end
        ST_PARITY: if (tick) begin
          if (tx_s_q == S_W'(OS_TICKS - 1)) begin
            tx_s_q  <= '0;
            tx_q    <= 1'b1;
            tx_st_q <= ST_STOP;
          end else tx_s_q <= tx_s_q + 1'b1;
        end
        ST_STOP: if (tick) begin
          if (tx_last) begin
            tx_st_q   <= ST_IDLE;
            tx_busy_q <= 1'b0;
          end else tx_s_q <= tx_s_q + 1'b1;
        end
        default: tx_st_q <= ST_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx          = tx_q;
  assign tx_busy     = tx_busy_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule
